// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS stopwatch counter with run, pause, adjust and clear
// modes. The count is kept as binary minute/second fields and converted to
// registered BCD digits on the same edge the fields change.
module stopwatch_core #(
  parameter int MAX_MIN = 59,
  parameter int MAX_SEC = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       rst_d,
  input  logic       pause_d,
  input  logic       adj_d,
  input  logic       sel_d,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       blink
);

  localparam logic [6:0] MAX_MIN_L = 7'(MAX_MIN);
  localparam logic [6:0] MAX_SEC_L = 7'(MAX_SEC);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PAUSED = 2'd1,
    ADJUST = 2'd2,
    CLEAR  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] min_q, min_d;
  logic [6:0] sec_q, sec_d;
  logic       running_q, running_d;
  logic       blink_q, blink_d;
  logic [7:0] min_bcd_q, min_bcd_d;
  logic [7:0] sec_bcd_q, sec_bcd_d;

  // Binary 0..99 to two BCD digits {tens, ones} by repeated subtraction.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    logic [6:0] rem;
    logic [3:0] tens;
    rem  = v;
    tens = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (rem >= 7'd10) begin
        rem  = rem - 7'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  // Increment with wrap to zero past the field maximum.
  function automatic logic [6:0] inc_wrap(input logic [6:0] v, input logic [6:0] max);
    return (v >= max) ? 7'd0 : v + 7'd1;
  endfunction

  // Mode resolution (priority clear > adjust > paused > run) and next count.
  // The mode comes straight from the current inputs so a pause or adjust
  // level takes effect on the same edge it is first sampled.
  always_comb begin
    state_d   = RUN;
    min_d     = min_q;
    sec_d     = sec_q;
    running_d = 1'b0;
    blink_d   = 1'b0;
    if (rst_d)        state_d = CLEAR;
    else if (adj_d)   state_d = ADJUST;
    else if (pause_d) state_d = PAUSED;
    else              state_d = RUN;

    case (state_d)
      CLEAR: begin
        min_d = 7'd0;
        sec_d = 7'd0;
      end
      ADJUST: begin
        // tick_1hz is deliberately ignored here; only the 2 Hz tick adjusts.
        blink_d = blink_q;
        if (tick_2hz) begin
          blink_d = ~blink_q;
          if (!pause_d) begin
            if (sel_d) sec_d = inc_wrap(sec_q, MAX_SEC_L);
            else       min_d = inc_wrap(min_q, MAX_MIN_L);
          end
        end
      end
      PAUSED: begin
      end
      default: begin
        running_d = 1'b1;
        if (tick_1hz) begin
          if (sec_q >= MAX_SEC_L) begin
            sec_d = 7'd0;
            min_d = inc_wrap(min_q, MAX_MIN_L);
          end else begin
            sec_d = sec_q + 7'd1;
          end
        end
      end
    endcase

    min_bcd_d = to_bcd(min_d);
    sec_bcd_d = to_bcd(sec_d);
  end

  // State, count fields and registered display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      min_q     <= 7'd0;
      sec_q     <= 7'd0;
      running_q <= 1'b0;
      blink_q   <= 1'b0;
      min_bcd_q <= 8'd0;
      sec_bcd_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      running_q <= running_d;
      blink_q   <= blink_d;
      min_bcd_q <= min_bcd_d;
      sec_bcd_q <= sec_bcd_d;
    end
  end

  assign min_tens = min_bcd_q[7:4];
  assign min_ones = min_bcd_q[3:0];
  assign sec_tens = sec_bcd_q[7:4];
  assign sec_ones = sec_bcd_q[3:0];
  assign running  = running_q && (state_q == RUN);
  assign blink    = blink_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed, table-driven bench for stopwatch_core.
module tb_stopwatch_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0, tick_2hz = 1'b0;
  logic       rst_d = 1'b0, pause_d = 1'b0, adj_d = 1'b0, sel_d = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, blink;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       rd, pd, ad, sd, t1, t2;
    logic [15:0] bcd;
    logic       run, blk;
  } vec_t;

  vec_t va[$];
  vec_t vb[$];

  stopwatch_core #(.MAX_MIN(59), .MAX_SEC(59)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .rst_d(rst_d), .pause_d(pause_d), .adj_d(adj_d), .sel_d(sel_d),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .blink(blink)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rd, input logic pd, input logic ad, input logic sd,
                              input logic t1, input logic t2, input logic [15:0] bcd,
                              input logic run, input logic blk);
    vec_t v;
    v.rd = rd; v.pd = pd; v.ad = ad; v.sd = sd; v.t1 = t1; v.t2 = t2;
    v.bcd = bcd; v.run = run; v.blk = blk;
    return v;
  endfunction

  // Drive one clock cycle of inputs; sample 1 time unit after the edge.
  task automatic cyc(input logic rd, input logic pd, input logic ad, input logic sd,
                     input logic t1, input logic t2);
    @(negedge clk);
    rst_d = rd; pause_d = pd; adj_d = ad; sel_d = sd; tick_1hz = t1; tick_2hz = t2;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] bcd, input logic run, input logic blk);
    logic [15:0] got;
    got = {min_tens, min_ones, sec_tens, sec_ones};
    checks++;
    if (got !== bcd || running !== run || blink !== blk) begin
      errors++;
      $display("FAIL %s: got %h run=%b blink=%b, want %h run=%b blink=%b",
               name, got, running, blink, bcd, run, blk);
    end
  endtask

  task automatic apply(input string name, input vec_t v);
    cyc(v.rd, v.pd, v.ad, v.sd, v.t1, v.t2);
    chk(name, v.bcd, v.run, v.blk);
  endtask

  initial begin
    // rd pd ad sd t1 t2 expected run blink
    va.push_back(mk(0,0,0,0,1,0, 16'h0001, 1, 0)); // run tick
    va.push_back(mk(0,0,0,0,1,1, 16'h0002, 1, 0)); // coincident ticks: +1 only
    va.push_back(mk(0,0,0,0,0,0, 16'h0002, 1, 0)); // idle
    va.push_back(mk(0,1,0,0,1,0, 16'h0002, 0, 0)); // pause rises with tick: not counted
    va.push_back(mk(0,1,0,0,1,0, 16'h0002, 0, 0));
    va.push_back(mk(0,1,0,0,1,1, 16'h0002, 0, 0));
    va.push_back(mk(0,1,0,0,1,0, 16'h0002, 0, 0));
    va.push_back(mk(0,1,0,0,1,0, 16'h0002, 0, 0));
    va.push_back(mk(0,0,0,0,0,0, 16'h0002, 1, 0)); // unpause
    va.push_back(mk(0,0,0,0,1,0, 16'h0003, 1, 0));
    va.push_back(mk(0,0,1,1,1,0, 16'h0003, 0, 0)); // adjust ignores 1 Hz
    va.push_back(mk(0,0,1,1,0,1, 16'h0004, 0, 1));
    va.push_back(mk(0,0,1,1,1,1, 16'h0005, 0, 0)); // coincident in adjust: +1
    va.push_back(mk(0,0,1,0,0,1, 16'h0105, 0, 1)); // select minutes
    va.push_back(mk(0,1,1,0,0,1, 16'h0105, 0, 0)); // paused adjust: blink only
    va.push_back(mk(0,1,1,0,0,1, 16'h0105, 0, 1));
    va.push_back(mk(0,0,0,0,0,0, 16'h0105, 1, 0)); // exit adjust: blink cleared
    va.push_back(mk(1,0,1,0,0,0, 16'h0000, 0, 0)); // clear

    vb.push_back(mk(0,0,1,1,0,1, 16'h0059, 0, 1));
    vb.push_back(mk(0,0,1,1,1,0, 16'h0059, 0, 1));
    vb.push_back(mk(0,0,1,1,0,1, 16'h0000, 0, 0)); // seconds wrap, no carry
    vb.push_back(mk(0,0,1,1,1,0, 16'h0000, 0, 0));
    vb.push_back(mk(0,0,1,1,0,1, 16'h0001, 0, 1));

    // Reset held with ticks active.
    #1 rst = 1'b0;
    #1 chk("rst_async_entry", 16'h0000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0,0,0,0,1,1);
      chk("rst_held", 16'h0000, 0, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    tick_1hz = 1'b0; tick_2hz = 1'b0;
    #1 chk("rst_released_pre_edge", 16'h0000, 0, 0);
    cyc(0,0,0,0,0,0);
    chk("rst_first_edge", 16'h0000, 1, 0);

    foreach (va[i]) apply($sformatf("vecA_%0d", i), va[i]);

    // Preload 59:58 through adjust, then roll over.
    for (int i = 0; i < 59; i++) cyc(0,0,1,0,0,1);
    for (int i = 0; i < 58; i++) cyc(0,0,1,1,0,1);
    cyc(0,1,0,0,0,0);
    chk("preload_5958", 16'h5958, 0, 0);
    cyc(0,0,0,0,1,0); chk("roll_5959", 16'h5959, 1, 0);
    cyc(0,0,0,0,1,0); chk("roll_0000", 16'h0000, 1, 0);
    cyc(0,0,0,0,1,0); chk("roll_0001", 16'h0001, 1, 0);

    // Minute carry from 00:59.
    for (int i = 0; i < 58; i++) cyc(0,0,1,1,0,1);
    cyc(0,1,0,0,0,0);
    chk("preload_0059", 16'h0059, 0, 0);
    cyc(0,0,0,0,1,0); chk("min_carry", 16'h0100, 1, 0);

    // Adjust seconds from 00:58 with interleaved 1 Hz ticks.
    cyc(1,0,0,0,0,0); chk("clear_b", 16'h0000, 0, 0);
    for (int i = 0; i < 58; i++) cyc(0,0,1,1,0,1);
    cyc(0,1,0,0,0,0);
    chk("preload_0058", 16'h0058, 0, 0);
    foreach (vb[i]) apply($sformatf("vecB_%0d", i), vb[i]);

    // Clear priority over adjust at 12:34.
    cyc(1,0,0,0,0,0); chk("clear_c", 16'h0000, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0,0,1,0,0,1);
    for (int i = 0; i < 34; i++) cyc(0,0,1,1,0,1);
    cyc(0,1,0,0,0,0);
    chk("preload_1234", 16'h1234, 0, 0);
    cyc(0,0,1,0,0,0); chk("adj_1234", 16'h1234, 0, 0);
    cyc(1,0,1,0,0,1); chk("clr_over_adj", 16'h0000, 0, 0);
    cyc(1,0,1,1,1,1); chk("clr_hold_ticks", 16'h0000, 0, 0);
    cyc(1,0,0,0,1,0); chk("clr_hold_run", 16'h0000, 0, 0);
    cyc(0,0,1,1,0,1); chk("clr_release_adj", 16'h0001, 0, 1);

    // Asynchronous reset mid-cycle.
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_async_mid", 16'h0000, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
